// File: rtl/tickgen_pkg.sv
// rtl/tickgen_pkg.sv - shared width and state definitions for the tick generator
package tickgen_pkg;

  localparam int TICK_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tickgen_state_e;

endpackage

// File: rtl/tick_generator_7bit_if.sv
// rtl/tick_generator_7bit_if.sv - control/status bundle between tick generator and its controller
interface tick_generator_7bit_if #(
  parameter int WIDTH = 7
);

  // controller -> generator
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] period;

  // generator -> controller
  logic             tick;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] remaining;

  modport master (
    output start,
    output stop,
    output auto_reload,
    output period,
    input  tick,
    input  busy,
    input  done,
    input  err,
    input  remaining
  );

  modport slave (
    input  start,
    input  stop,
    input  auto_reload,
    input  period,
    output tick,
    output busy,
    output done,
    output err,
    output remaining
  );

endinterface

// File: rtl/tick_generator_7bit.sv
// rtl/tick_generator_7bit.sv - programmable down-counting tick generator, one-shot or auto-reload
module tick_generator_7bit
  import tickgen_pkg::*;
#(
  parameter int WIDTH = TICK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tick_generator_7bit_if.slave  bus
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  tickgen_state_e   state_q,     state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] period_q,    period_d;
  logic             mode_q,      mode_d;
  logic             tick_q,      tick_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             err_q,       err_d;

  logic             start_ok;
  logic             start_bad;

  // A start is only usable with a nonzero period; zero periods are flagged instead.
  always_comb begin
    start_ok  = bus.start && (bus.period != ZERO);
    start_bad = bus.start && (bus.period == ZERO);
  end

  // Next-state, counter and flag computation; stop always wins over expiry.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    mode_d      = mode_q;
    tick_d      = 1'b0;
    done_d      = done_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start_ok && !bus.stop) begin
          period_d    = bus.period;
          mode_d      = bus.auto_reload;
          remaining_d = bus.period;
          state_d     = RUN;
        end else if (start_bad) begin
          err_d = 1'b1;
        end
      end

      RUN: begin
        if (bus.stop) begin
          remaining_d = ZERO;
          state_d     = IDLE;
        end else if (remaining_q > ONE) begin
          remaining_d = remaining_q - ONE;
        end else if (remaining_q == ONE) begin
          tick_d = 1'b1;
          if (mode_q) begin
            // period_q is never zero here, so a reload cannot stall the counter
            remaining_d = period_q;
          end else begin
            remaining_d = ZERO;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end else begin
          // unreachable with a legal latched period; fall back to idle rather than hang
          remaining_d = ZERO;
          state_d     = IDLE;
        end
      end

      DONE: begin
        if (bus.stop) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end else if (start_ok) begin
          done_d      = 1'b0;
          period_d    = bus.period;
          mode_d      = bus.auto_reload;
          remaining_d = bus.period;
          state_d     = RUN;
        end else if (start_bad) begin
          err_d = 1'b1;
        end
      end

      default: begin
        remaining_d = ZERO;
        done_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= ZERO;
      period_q    <= ZERO;
      mode_q      <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
      mode_q      <= mode_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_tick_generator_7bit.sv
// tb/tb_tick_generator_7bit.sv - directed self-checking bench for tick_generator_7bit
module tb_tick_generator_7bit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  tick_generator_7bit_if #(.WIDTH(7)) ifc ();

  tick_generator_7bit #(.WIDTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, return at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [6:0] p, input logic ar);
    ifc.start = 1'b1; ifc.period = p; ifc.auto_reload = ar;
    step();
    ifc.start = 1'b0; ifc.period = 7'd0; ifc.auto_reload = 1'b0;
  endtask

  task automatic do_stop();
    ifc.stop = 1'b1;
    step();
    ifc.stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.auto_reload = 1'b0; ifc.period = 7'd0;
    step(); step();
    vectors++; if (ifc.tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got %b exp 0", ifc.tick); end
    vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", ifc.busy); end
    vectors++; if (ifc.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", ifc.done); end
    vectors++; if (ifc.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", ifc.err); end
    vectors++; if (ifc.remaining !== 7'd0) begin miscompares++; $display("FAIL reset_remaining got %0d exp 0", ifc.remaining); end
    rst_n = 1'b1;
    step();
    // stop alone in IDLE does nothing
    do_stop();
    vectors++; if (ifc.busy !== 1'b0 || ifc.remaining !== 7'd0) begin miscompares++; $display("FAIL idle_stop got busy=%b rem=%0d exp busy=0 rem=0", ifc.busy, ifc.remaining); end
  endtask

  task automatic test_one_shot();
    do_start(7'd4, 1'b0);
    vectors++; if (ifc.busy !== 1'b1 || ifc.remaining !== 7'd4) begin miscompares++; $display("FAIL os_start got busy=%b rem=%0d exp busy=1 rem=4", ifc.busy, ifc.remaining); end
    for (int k = 1; k <= 3; k++) begin
      step();
      vectors++; if (ifc.remaining !== 7'(4 - k) || ifc.tick !== 1'b0) begin miscompares++; $display("FAIL os_count%0d got rem=%0d tick=%b exp rem=%0d tick=0", k, ifc.remaining, ifc.tick, 4 - k); end
    end
    step();
    vectors++; if (ifc.tick !== 1'b1) begin miscompares++; $display("FAIL os_tick got %b exp 1", ifc.tick); end
    vectors++; if (ifc.done !== 1'b1) begin miscompares++; $display("FAIL os_done got %b exp 1", ifc.done); end
    vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL os_busy got %b exp 0", ifc.busy); end
    vectors++; if (ifc.remaining !== 7'd0) begin miscompares++; $display("FAIL os_rem got %0d exp 0", ifc.remaining); end
    step(); step(); step();
    vectors++; if (ifc.tick !== 1'b0 || ifc.done !== 1'b1) begin miscompares++; $display("FAIL os_hold got tick=%b done=%b exp tick=0 done=1", ifc.tick, ifc.done); end
    do_stop();
    vectors++; if (ifc.done !== 1'b0) begin miscompares++; $display("FAIL os_clear got %b exp 0", ifc.done); end
  endtask

  task automatic test_auto_reload();
    int ticks;
    ticks = 0;
    do_start(7'd3, 1'b1);
    for (int e = 1; e <= 10; e++) begin
      step();
      if (ifc.tick === 1'b1) ticks++;
      vectors++; if (ifc.tick !== ((e % 3) == 0) || ifc.busy !== 1'b1) begin miscompares++; $display("FAIL ar_edge%0d got tick=%b busy=%b exp tick=%b busy=1", e, ifc.tick, ifc.busy, (e % 3) == 0); end
      vectors++; if (ifc.remaining !== 7'(3 - (e % 3))) begin miscompares++; $display("FAIL ar_rem%0d got %0d exp %0d", e, ifc.remaining, 3 - (e % 3)); end
      // a start while running must be ignored
      if (e == 1) begin ifc.start = 1'b1; ifc.period = 7'd7; ifc.auto_reload = 1'b0; end
      if (e == 2) begin ifc.start = 1'b0; ifc.period = 7'd0; end
    end
    vectors++; if (ticks !== 3) begin miscompares++; $display("FAIL ar_count got %0d exp 3", ticks); end
    do_stop();
    vectors++; if (ifc.busy !== 1'b0 || ifc.remaining !== 7'd0 || ifc.tick !== 1'b0) begin miscompares++; $display("FAIL ar_stop got busy=%b rem=%0d tick=%b exp 0 0 0", ifc.busy, ifc.remaining, ifc.tick); end
  endtask

  task automatic test_period_one();
    do_start(7'd1, 1'b1);
    vectors++; if (ifc.remaining !== 7'd1 || ifc.tick !== 1'b0) begin miscompares++; $display("FAIL p1_start got rem=%0d tick=%b exp rem=1 tick=0", ifc.remaining, ifc.tick); end
    for (int e = 1; e <= 5; e++) begin
      step();
      vectors++; if (ifc.tick !== 1'b1 || ifc.remaining !== 7'd1) begin miscompares++; $display("FAIL p1_edge%0d got tick=%b rem=%0d exp tick=1 rem=1", e, ifc.tick, ifc.remaining); end
    end
    do_stop();
    vectors++; if (ifc.tick !== 1'b0 || ifc.busy !== 1'b0) begin miscompares++; $display("FAIL p1_stop got tick=%b busy=%b exp 0 0", ifc.tick, ifc.busy); end
  endtask

  task automatic test_period_max();
    int ticks;
    int tick_edge;
    ticks = 0; tick_edge = -1;
    do_start(7'd127, 1'b0);
    for (int e = 1; e <= 130; e++) begin
      step();
      if (ifc.tick === 1'b1) begin ticks++; tick_edge = e; end
    end
    vectors++; if (ticks !== 1) begin miscompares++; $display("FAIL p127_count got %0d exp 1", ticks); end
    vectors++; if (tick_edge !== 127) begin miscompares++; $display("FAIL p127_edge got %0d exp 127", tick_edge); end
    vectors++; if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin miscompares++; $display("FAIL p127_done got done=%b busy=%b exp 1 0", ifc.done, ifc.busy); end
  endtask

  task automatic test_err();
    // currently in DONE: zero period start gives err and keeps DONE
    do_start(7'd0, 1'b0);
    vectors++; if (ifc.err !== 1'b1 || ifc.done !== 1'b1) begin miscompares++; $display("FAIL err_done got err=%b done=%b exp 1 1", ifc.err, ifc.done); end
    // legal start from DONE restarts and clears done
    do_start(7'd2, 1'b0);
    vectors++; if (ifc.err !== 1'b0 || ifc.done !== 1'b0 || ifc.busy !== 1'b1 || ifc.remaining !== 7'd2) begin miscompares++; $display("FAIL done_restart got err=%b done=%b busy=%b rem=%0d exp 0 0 1 2", ifc.err, ifc.done, ifc.busy, ifc.remaining); end
    do_stop();
    do_start(7'd0, 1'b1);
    vectors++; if (ifc.err !== 1'b1 || ifc.busy !== 1'b0) begin miscompares++; $display("FAIL err_idle got err=%b busy=%b exp 1 0", ifc.err, ifc.busy); end
    step();
    vectors++; if (ifc.err !== 1'b0 || ifc.busy !== 1'b0) begin miscompares++; $display("FAIL err_pulse got err=%b busy=%b exp 0 0", ifc.err, ifc.busy); end
  endtask

  task automatic test_stop_at_expiry();
    do_start(7'd2, 1'b0);
    step();
    vectors++; if (ifc.remaining !== 7'd1) begin miscompares++; $display("FAIL se_rem got %0d exp 1", ifc.remaining); end
    do_stop();
    vectors++; if (ifc.tick !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.remaining !== 7'd0) begin miscompares++; $display("FAIL se_stop got tick=%b busy=%b done=%b rem=%0d exp 0 0 0 0", ifc.tick, ifc.busy, ifc.done, ifc.remaining); end
    step();
    vectors++; if (ifc.tick !== 1'b0 || ifc.done !== 1'b0) begin miscompares++; $display("FAIL se_after got tick=%b done=%b exp 0 0", ifc.tick, ifc.done); end
  endtask

  task automatic test_reset_mid_run();
    do_start(7'd5, 1'b1);
    step(); step(); step();
    vectors++; if (ifc.remaining !== 7'd2 || ifc.busy !== 1'b1) begin miscompares++; $display("FAIL rm_pre got rem=%0d busy=%b exp 2 1", ifc.remaining, ifc.busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (ifc.tick !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.err !== 1'b0 || ifc.remaining !== 7'd0) begin miscompares++; $display("FAIL rm_async got tick=%b busy=%b done=%b err=%b rem=%0d exp all 0", ifc.tick, ifc.busy, ifc.done, ifc.err, ifc.remaining); end
    step(); step(); step();
    vectors++; if (ifc.tick !== 1'b0 || ifc.busy !== 1'b0) begin miscompares++; $display("FAIL rm_held got tick=%b busy=%b exp 0 0", ifc.tick, ifc.busy); end
    rst_n = 1'b1;
    step();
    do_start(7'd2, 1'b0);
    vectors++; if (ifc.remaining !== 7'd2 || ifc.busy !== 1'b1) begin miscompares++; $display("FAIL rm_restart got rem=%0d busy=%b exp 2 1", ifc.remaining, ifc.busy); end
    step();
    vectors++; if (ifc.remaining !== 7'd1 || ifc.tick !== 1'b0) begin miscompares++; $display("FAIL rm_count got rem=%0d tick=%b exp 1 0", ifc.remaining, ifc.tick); end
    step();
    vectors++; if (ifc.tick !== 1'b1 || ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin miscompares++; $display("FAIL rm_expire got tick=%b done=%b busy=%b exp 1 1 0", ifc.tick, ifc.done, ifc.busy); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_period_one();
    test_period_max();
    test_err();
    test_stop_at_expiry();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
